// File: rtl/ysyx_23060236_rf_pkg.sv
// Shared sizing and packing helpers for the scoreboarded register file.
package ysyx_23060236_rf_pkg;

  localparam int X0 = 0;

  function automatic int nregs(input int aw);
    return 1 << aw;
  endfunction

  function automatic int cnt_max(input int cw);
    return (1 << cw) - 1;
  endfunction

  // LSB of read port 'port' inside a flat packed bus of 'w'-bit fields
  function automatic int port_lsb(input int port, input int w);
    return port * w;
  endfunction

endpackage

// File: rtl/ysyx_23060236_sb_counter.sv
// Saturating pending-write counter for one register; clr wins, inc+dec cancel.
module ysyx_23060236_sb_counter
  import ysyx_23060236_rf_pkg::*;
#(
  parameter int CNT_WIDTH = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 inc,
  input  logic                 dec,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 is_zero,
  output logic                 is_max,
  output logic                 underflow
);

  localparam logic [CNT_WIDTH-1:0] CMAX = CNT_WIDTH'(cnt_max(CNT_WIDTH));

  assign is_zero   = (cnt == '0);
  assign is_max    = (cnt == CMAX);
  assign underflow = dec & ~inc & ~clr & is_zero;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                        cnt <= '0;
    else if (clr)                     cnt <= '0;
    else if (inc & ~dec & ~is_max)    cnt <= cnt + 1'b1;
    else if (dec & ~inc & ~is_zero)   cnt <= cnt - 1'b1;
  end

endmodule

// File: rtl/ysyx_23060236_regfile_sb.sv
// Multi-read-port register file with per-register pending-write scoreboard,
// optional writeback bypass, flush and sticky retire-underflow error.
module ysyx_23060236_regfile_sb
  import ysyx_23060236_rf_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int NR_READ    = 2,
  parameter int CNT_WIDTH  = 2,
  parameter int BYPASS     = 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NR_READ*ADDR_WIDTH-1:0] raddr,
  output logic [NR_READ*DATA_WIDTH-1:0] rdata,
  output logic [NR_READ-1:0]            rbusy,
  input  logic                          issue_valid,
  input  logic [ADDR_WIDTH-1:0]         issue_rd,
  output logic                          issue_ready,
  input  logic                          wb_valid,
  input  logic [ADDR_WIDTH-1:0]         wb_addr,
  input  logic [DATA_WIDTH-1:0]         wb_data,
  input  logic                          flush,
  output logic                          sb_err
);

  localparam int                    NREGS    = nregs(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(X0);

  logic [DATA_WIDTH-1:0]             rf [NREGS];
  logic [NREGS-1:0][CNT_WIDTH-1:0]   cnt;
  logic [NREGS-1:0]                  is_zero, is_max, underflow;
  logic                              fire, retire;

  assign retire      = wb_valid & (wb_addr != ZERO_IDX);
  assign issue_ready = (issue_rd == ZERO_IDX) | ~is_max[issue_rd];
  assign fire        = issue_valid & issue_ready & (issue_rd != ZERO_IDX);

  // x0 is never tracked: permanently idle, never full
  assign cnt[0]       = '0;
  assign is_zero[0]   = 1'b1;
  assign is_max[0]    = 1'b0;
  assign underflow[0] = 1'b0;

  for (genvar r = 1; r < NREGS; r++) begin : g_cnt
    ysyx_23060236_sb_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
      .clock     (clock),
      .reset     (reset),
      .inc       (fire   & (issue_rd == ADDR_WIDTH'(r))),
      .dec       (retire & (wb_addr  == ADDR_WIDTH'(r))),
      .clr       (flush),
      .cnt       (cnt[r]),
      .is_zero   (is_zero[r]),
      .is_max    (is_max[r]),
      .underflow (underflow[r])
    );
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) rf[r] <= '0;
    end else if (retire) begin
      rf[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)           sb_err <= 1'b0;
    else if (|underflow) sb_err <= 1'b1;
  end

  for (genvar i = 0; i < NR_READ; i++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic                  hit, last;
    assign ra   = raddr[port_lsb(i, ADDR_WIDTH) +: ADDR_WIDTH];
    assign hit  = (BYPASS != 0) & retire & (wb_addr == ra);
    // the writeback that retires the last pending write frees the operand now
    assign last = (cnt[ra] == CNT_WIDTH'(1));
    assign rdata[port_lsb(i, DATA_WIDTH) +: DATA_WIDTH] =
      (ra == ZERO_IDX) ? '0 : hit ? wb_data : rf[ra];
    assign rbusy[i] = (ra != ZERO_IDX) & ~is_zero[ra] & ~(hit & last);
  end

endmodule

// File: tb/tb_ysyx_23060236_regfile_sb.sv
// Directed scoreboard bench: stimulus queues expectations, a negedge monitor checks them.
module tb_ysyx_23060236_regfile_sb;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  raddr;
  logic [63:0] rdata;
  logic [1:0]  rbusy;
  logic        issue_valid;
  logic [3:0]  issue_rd;
  logic        issue_ready;
  logic        wb_valid;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic        flush;
  logic        sb_err;

  ysyx_23060236_regfile_sb #(
    .ADDR_WIDTH(4), .DATA_WIDTH(32), .NR_READ(2), .CNT_WIDTH(2), .BYPASS(1)
  ) dut (
    .clock(clock), .reset(reset), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush), .sb_err(sb_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [63:0] rd;
    logic [1:0]  busy;
    logic        rdy;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  always @(negedge clock) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks += 4;
      if (rdata !== e.rd) begin
        failures++;
        $display("FAIL %s rdata got=%h want=%h", e.name, rdata, e.rd);
      end
      if (rbusy !== e.busy) begin
        failures++;
        $display("FAIL %s rbusy got=%b want=%b", e.name, rbusy, e.busy);
      end
      if (issue_ready !== e.rdy) begin
        failures++;
        $display("FAIL %s issue_ready got=%b want=%b", e.name, issue_ready, e.rdy);
      end
      if (sb_err !== e.err) begin
        failures++;
        $display("FAIL %s sb_err got=%b want=%b", e.name, sb_err, e.err);
      end
    end
  end

  task automatic step(input string nm, input logic [3:0] a0, input logic [3:0] a1,
                      input logic iv, input logic [3:0] ird,
                      input logic wv, input logic [3:0] wa, input logic [31:0] wd,
                      input logic fl,
                      input logic [31:0] e0, input logic [31:0] e1,
                      input logic [1:0] eb, input logic er, input logic ee);
    exp_t e;
    raddr       = {a1, a0};
    issue_valid = iv;
    issue_rd    = ird;
    wb_valid    = wv;
    wb_addr     = wa;
    wb_data     = wd;
    flush       = fl;
    e.name = nm; e.rd = {e1, e0}; e.busy = eb; e.rdy = er; e.err = ee;
    q.push_back(e);
    @(posedge clock);
    #1;
  endtask

  // read-only cycle
  task automatic rd(input string nm, input logic [3:0] a0, input logic [3:0] a1,
                    input logic [31:0] e0, input logic [31:0] e1,
                    input logic [1:0] eb, input logic ee);
    step(nm, a0, a1, 1'b0, 4'd0, 1'b0, 4'd0, 32'h0, 1'b0, e0, e1, eb, 1'b1, ee);
  endtask

  initial begin
    reset = 1'b1;
    raddr = '0; issue_valid = 0; issue_rd = '0; wb_valid = 0; wb_addr = '0;
    wb_data = '0; flush = 0;
    @(posedge clock); #1;
    rd("in_reset", 4'd5, 4'd9, 0, 0, 2'b00, 0);
    reset = 1'b0;
    for (int i = 0; i < 16; i++)
      rd("reset_read", 4'(i), 4'(15 - i), 0, 0, 2'b00, 0);

    // issue then bypassed writeback on reg 5
    step("iss5",    4'd5, 4'd0, 1, 4'd5, 0, 4'd0, 0, 0, 0, 0, 2'b00, 1, 0);
    rd  ("busy5",   4'd5, 4'd5, 0, 0, 2'b11, 0);
    step("wb5",     4'd5, 4'd0, 0, 4'd0, 1, 4'd5, 32'hDEADBEEF, 0,
         32'hDEADBEEF, 0, 2'b00, 1, 0);
    rd  ("after5",  4'd5, 4'd5, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 0);

    // saturate reg 3
    step("iss3a",   4'd3, 4'd0, 1, 4'd3, 0, 4'd0, 0, 0, 0, 0, 2'b00, 1, 0);
    step("iss3b",   4'd3, 4'd0, 1, 4'd3, 0, 4'd0, 0, 0, 0, 0, 2'b01, 1, 0);
    step("iss3c",   4'd3, 4'd0, 1, 4'd3, 0, 4'd0, 0, 0, 0, 0, 2'b01, 1, 0);
    step("iss3full",4'd3, 4'd0, 1, 4'd3, 0, 4'd0, 0, 0, 0, 0, 2'b01, 0, 0);
    step("wb3a",    4'd3, 4'd3, 0, 4'd3, 1, 4'd3, 32'h33, 0,
         32'h33, 32'h33, 2'b11, 0, 0);
    step("rdy3",    4'd3, 4'd0, 0, 4'd3, 0, 4'd0, 0, 0, 32'h33, 0, 2'b01, 1, 0);
    step("wb3b",    4'd3, 4'd0, 0, 4'd0, 1, 4'd3, 32'h34, 0, 32'h34, 0, 2'b01, 1, 0);
    step("wb3c",    4'd3, 4'd0, 0, 4'd0, 1, 4'd3, 32'h35, 0, 32'h35, 0, 2'b00, 1, 0);
    rd  ("idle3",   4'd3, 4'd0, 32'h35, 0, 2'b00, 0);

    // simultaneous issue and retire on reg 7
    step("iss7",    4'd7, 4'd0, 1, 4'd7, 0, 4'd0, 0, 0, 0, 0, 2'b00, 1, 0);
    step("isswb7",  4'd7, 4'd0, 1, 4'd7, 1, 4'd7, 32'h77, 0, 32'h77, 0, 2'b00, 1, 0);
    rd  ("still7",  4'd7, 4'd0, 32'h77, 0, 2'b01, 0);
    step("wb7",     4'd7, 4'd0, 0, 4'd0, 1, 4'd7, 32'h78, 0, 32'h78, 0, 2'b00, 1, 0);

    // flush
    step("iss4",    4'd4, 4'd0, 1, 4'd4, 0, 4'd0, 0, 0, 0, 0, 2'b00, 1, 0);
    step("iss9",    4'd4, 4'd0, 1, 4'd9, 0, 4'd0, 0, 0, 0, 0, 2'b01, 1, 0);
    step("flushiss",4'd4, 4'd9, 1, 4'd9, 0, 4'd0, 0, 1, 0, 0, 2'b11, 1, 0);
    rd  ("flushed", 4'd4, 4'd9, 0, 0, 2'b00, 0);
    step("flushwb6",4'd6, 4'd0, 0, 4'd0, 1, 4'd6, 32'h66, 1, 32'h66, 0, 2'b00, 1, 0);
    rd  ("noerr6",  4'd6, 4'd0, 32'h66, 0, 2'b00, 0);
    step("isswb10", 4'd10, 4'd0, 1, 4'd10, 1, 4'd10, 32'hA0, 0, 32'hA0, 0, 2'b00, 1, 0);
    rd  ("noerr10", 4'd10, 4'd0, 32'hA0, 0, 2'b00, 0);
    step("uflow4",  4'd4, 4'd0, 0, 4'd0, 1, 4'd4, 32'hABCD, 0, 32'hABCD, 0, 2'b00, 1, 0);
    rd  ("err4",    4'd4, 4'd0, 32'hABCD, 0, 2'b00, 1);

    // x0
    step("x0",      4'd0, 4'd0, 1, 4'd0, 1, 4'd0, 32'h1234, 0, 0, 0, 2'b00, 1, 1);
    rd  ("x0after", 4'd0, 4'd0, 0, 0, 2'b00, 1);
    rd  ("errstick",4'd6, 4'd0, 32'h66, 0, 2'b00, 1);

    // reset mid-operation
    step("iss2",    4'd2, 4'd0, 1, 4'd2, 0, 4'd0, 0, 0, 0, 0, 2'b00, 1, 1);
    rd  ("busy2",   4'd2, 4'd5, 0, 32'hDEADBEEF, 2'b01, 1);
    #2 reset = 1'b1;
    rd  ("midreset",4'd2, 4'd5, 0, 0, 2'b00, 0);
    reset = 1'b0;
    rd  ("postrst", 4'd2, 4'd5, 0, 0, 2'b00, 0);

    for (int n = 0; n < 10 && q.size() > 0; n++) @(posedge clock);
    if (q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d want=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ysyx_23060236_regfile_sb.md
# ysyx_23060236_regfile_sb

Parametrised register file with an integrated write scoreboard. It replaces the plain two-read/one-write register file in the pipelined core. It has N read ports with optional same-cycle write bypass, and a per-register pending-write counter that marks operands busy between issue and writeback. A flush input discards all in-flight writes. It sits between the decode/issue stage (reads, issue) and the writeback stage (writes, retire).

## Interface
Parameters:
- ADDR_WIDTH, 4: register index width; 2**ADDR_WIDTH architectural registers, index 0 hardwired to zero.
- DATA_WIDTH, 32: register width.
- NR_READ, 2: number of read ports (1..4).
- CNT_WIDTH, 2: pending-write counter width; max outstanding writes per register = 2**CNT_WIDTH-1.
- BYPASS, 1: 1 = writeback data forwarded to same-cycle reads; 0 = no forwarding.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- raddr  in  NR_READ*ADDR_WIDTH  read addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- rdata  out  NR_READ*DATA_WIDTH  read data, same packing.
- rbusy  out  NR_READ  port i operand has an unretired pending write.
- issue_valid  in  1  issue stage allocates a write to issue_rd.
- issue_rd  in  ADDR_WIDTH  destination of the issued instruction.
- issue_ready  out  1  issue_rd counter not saturated.
- wb_valid  in  1  writeback of wb_data to wb_addr; retires one pending write.
- wb_addr  in  ADDR_WIDTH  writeback destination.
- wb_data  in  DATA_WIDTH  writeback value.
- flush  in  1  clears every pending counter; registers untouched.
- sb_err  out  1  sticky: retire seen on a register with zero count.

## Operation
- Register 0: reads return 0, rbusy=0, never written, never counted; issue_ready=1 for issue_rd=0.
- Write: wb_valid & wb_addr!=0 -> rf[wb_addr] <= wb_data at posedge.
- Issue fires when issue_valid & issue_ready & issue_rd!=0 -> cnt[issue_rd] +1.
- Retire: wb_valid & wb_addr!=0 -> cnt[wb_addr] -1. If the count is already 0, the count stays 0 and sb_err sets.
- A fire and a retire to the same register in the same cycle leave the count unchanged. This holds even when the count is at max or 0, and sb_err does not set.
- issue_ready = (issue_rd==0) | (cnt[issue_rd] != max). It ignores any same-cycle retire.
- issue_valid with issue_ready=0: ignored; the count does not change.
- rbusy[i] = raddr_i!=0 & cnt[raddr_i]!=0, except when BYPASS=1 & wb_valid & wb_addr==raddr_i & cnt==1: then rbusy[i]=0 and rdata_i=wb_data.
- BYPASS=1 & wb_valid & wb_addr==raddr_i!=0 -> rdata_i=wb_data regardless of count. BYPASS=0 -> rdata_i shows the old value until the next cycle.
- Flush: all counts <= 0 at posedge. It overrides any same-cycle issue. A same-cycle wb still writes data, but it does not count as a retire and does not set sb_err.
- sb_err clears only on reset.

## Timing
- Reads, rbusy, issue_ready: combinational, 0-cycle latency.
- Write, counter and sb_err updates: registered, visible the cycle after the posedge.
- Reset (asynchronous assert, synchronous-safe deassert): all rf entries 0, all counts 0, sb_err 0. Resulting outputs: rdata 0, rbusy 0, issue_ready 1. Reset asserted mid-operation discards in-flight state immediately.

## Structure
- Shared package ysyx_23060236_rf_pkg holds: register count, x0 index, counter max expression, read-port packing helpers.
- One sub-module: ysyx_23060236_sb_counter. It is a saturating up/down counter with inc, dec, clr inputs, zero/max flags and an underflow pulse. It is instantiated per register 1..2**ADDR_WIDTH-1.
- Top level contains the rf array, a bypass mux per read port, the issue_ready mux, and the sb_err OR-reduce.

## Test plan
- Reset, then read all 16 regs on both ports -> rdata=0, rbusy=0, issue_ready=1, sb_err=0.
- Issue rd=5, next cycle raddr0=5 -> rbusy[0]=1. Then wb 5<=0xDEAD_BEEF -> same cycle rdata0=0xDEADBEEF, rbusy[0]=0 (BYPASS=1); next cycle count 0.
- Issue rd=3 three times (CNT_WIDTH=2) -> issue_ready=0 for rd=3. A fourth issue is ignored. One wb to 3 -> issue_ready=1 and count 2.
- Same-cycle issue rd=7 and wb 7 with count 1 -> count stays 1 and rbusy stays 1.
- Issue rd=4, rd=9, then flush -> all rbusy=0. Then wb to 4 with count 0 after the flush -> data written and sb_err=1 next cycle.
- Writes and an issue to x0 with wb_data 0x1234 -> reads of x0 return 0, rbusy=0, no count change.
